// File: rtl/exp_vector_sequencer_pkg.sv
// Shared definitions for the softmax exp sequencer: S3.4 format, FSM states,
// sum width derivation and the saturating S3.4 clamp.
package exp_vector_sequencer_pkg;

  localparam int TOTAL_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EXP  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic int sum_width(input int vec_len);
    return TOTAL_WIDTH + $clog2(vec_len);
  endfunction

  // One-bit-wider difference back into S3.4: saturate when the top two bits disagree.
  function automatic logic signed [TOTAL_WIDTH-1:0] sat_s34(input logic signed [TOTAL_WIDTH:0] v);
    if (v[TOTAL_WIDTH] != v[TOTAL_WIDTH-1])
      sat_s34 = v[TOTAL_WIDTH] ? {1'b1, {(TOTAL_WIDTH-1){1'b0}}} : {1'b0, {(TOTAL_WIDTH-1){1'b1}}};
    else
      sat_s34 = v[TOTAL_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/exp_vector_sequencer_exp_approx.sv
// exp_approx: combinational S3.4 e^x via 2^(x*1.4375), linear mantissa
// 1+frac, result saturated to [0, 127].
module exp_approx
  import exp_vector_sequencer_pkg::*;
(
  input  logic signed [TOTAL_WIDTH-1:0] x,
  output logic signed [TOTAL_WIDTH-1:0] y
);

  logic signed [8:0] t;
  logic signed [4:0] ip;
  logic        [4:0] mant;
  logic        [2:0] rsh;

  always_comb begin
    // t = floor(x*23/16): log2(e) scaling kept in S.4 units
    t    = 9'((13'(x) * 13'sd23) >>> 4);
    ip   = t[8:4];
    mant = {1'b1, t[3:0]};
    rsh  = 3'(-ip);
    y    = '0;
    if (!ip[4]) begin
      if (ip >= 5'sd3)
        y = 8'sd127;
      else
        y = 8'({3'b000, mant} << ip[1:0]);
    end else if (ip <= -5'sd5) begin
      y = '0;
    end else begin
      y = 8'({3'b000, mant} >> rsh);
    end
  end

endmodule

// File: rtl/exp_vector_sequencer.sv
// Softmax numerator/denominator sequencer: buffers a vector, streams exp(x-max)
// and the sum. Max subtraction is compiled in with EXP_SEQ_MAX_SUB_EN.
module exp_vector_sequencer
  import exp_vector_sequencer_pkg::*;
#(
  parameter  int VEC_LEN = 8,
  localparam int SUM_W   = sum_width(VEC_LEN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [TOTAL_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [TOTAL_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          sum_valid,
  output logic        [SUM_W-1:0]       sum_out,
  output logic                          busy
);

  localparam int              IDX_W    = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  seq_state_t state, state_nxt;

  logic signed [TOTAL_WIDTH-1:0] vbuf [VEC_LEN];
  logic        [IDX_W-1:0]       wr_idx, rd_idx, rd_idx_nxt;
  logic        [SUM_W-1:0]       acc, acc_add;
  logic                          accept, load_done, out_hs, exp_done;
  logic signed [TOTAL_WIDTH-1:0] exp_src, exp_x, exp_y;

  assign in_ready   = (state == ST_LOAD);
  assign busy       = (state != ST_LOAD);
  assign accept     = in_valid & in_ready;
  assign load_done  = accept && (wr_idx == LAST_IDX);
  assign out_hs     = (state == ST_EXP) && out_valid && out_ready;
  assign exp_done   = out_hs && (rd_idx == LAST_IDX);
  assign rd_idx_nxt = exp_done ? '0 : rd_idx + 1'b1;
  assign acc_add    = acc + {{(SUM_W-TOTAL_WIDTH){1'b0}}, out_data};

  // Result is prefetched: element 0 on the final load, element rd_idx+1 on each handshake.
  assign exp_src = (state == ST_LOAD) ? vbuf[0] : vbuf[rd_idx_nxt];

`ifdef EXP_SEQ_MAX_SUB_EN
  logic signed [TOTAL_WIDTH-1:0] max_r, max_eff;

  // On the final load the incoming element still has to take part in the max.
  assign max_eff = ((state == ST_LOAD) && (in_data > max_r)) ? in_data : max_r;
  assign exp_x   = sat_s34({exp_src[TOTAL_WIDTH-1], exp_src} - {max_eff[TOTAL_WIDTH-1], max_eff});

  always_ff @(posedge clk) begin
    if (rst)
      max_r <= '0;
    else if (accept && ((wr_idx == '0) || (in_data > max_r)))
      max_r <= in_data;
  end
`else
  assign exp_x = exp_src;
`endif

  exp_approx u_exp_approx (
    .x (exp_x),
    .y (exp_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (load_done) state_nxt = ST_EXP;
      ST_EXP:  if (exp_done)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) vbuf[wr_idx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
    end else begin
      sum_valid <= 1'b0;
      if (accept) begin
        wr_idx <= load_done ? '0 : wr_idx + 1'b1;
        if (wr_idx == '0) acc <= '0;
      end
      if (load_done) begin
        rd_idx    <= '0;
        out_valid <= 1'b1;
        out_data  <= exp_y;
        out_last  <= 1'b0;
      end
      if (out_hs) begin
        acc <= acc_add;
        if (exp_done) begin
          rd_idx    <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          sum_out   <= acc_add;
          sum_valid <= 1'b1;
        end else begin
          rd_idx   <= rd_idx_nxt;
          out_data <= exp_y;
          out_last <= (rd_idx_nxt == LAST_IDX);
        end
      end
    end
  end

endmodule

// File: tb/tb_exp_vector_sequencer.sv
// Directed bench for exp_vector_sequencer; expected values are hand-computed
// for both EXP_SEQ_MAX_SUB_EN builds.
module tb_exp_vector_sequencer;
  import exp_vector_sequencer_pkg::*;

  localparam int VL = 8;
  localparam int SW = TOTAL_WIDTH + $clog2(VL);

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_last, sum_valid, busy;
  logic signed [7:0] in_data, out_data;
  logic [SW-1:0] sum_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic signed [7:0] vin [VL];
  int exp_out [VL];
  int exp_sum;

  always #5 clk = ~clk;

  exp_vector_sequencer #(.VEC_LEN(VL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sum_valid (sum_valid),
    .sum_out   (sum_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Caller is at a negedge in LOAD; returns at the negedge of the first EXP cycle.
  task automatic load_vec();
    for (int i = 0; i < VL; i++) begin
      in_valid = 1'b1;
      in_data  = vin[i];
      chk("in_ready_load", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("busy_exp", 32'(busy), 32'd1);
    chk("in_ready_exp0", 32'(in_ready), 32'd0);
  endtask

  // Consumes VL outputs (optionally stalling 3 cycles on element stall_at), then checks DONE.
  task automatic drain(input int stall_at);
    int k, stalls, budget;
    k = 0; stalls = 0; budget = 0;
    out_ready = 1'b1;
    while (k < VL && budget < 60) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("in_ready_exp", 32'(in_ready), 32'd0);
      if (out_valid) begin
        chk($sformatf("out_data[%0d]", k), 32'(out_data), 32'(exp_out[k]));
        chk($sformatf("out_last[%0d]", k), 32'(out_last), (k == VL-1) ? 32'd1 : 32'd0);
      end
      if (k == stall_at && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) k++;
      end
      @(negedge clk);
      budget++;
    end
    out_ready = 1'b1;
    chk("out_count", 32'(k), 32'(VL));
    chk("sum_valid_done", 32'(sum_valid), 32'd1);
    chk("sum_out", 32'(sum_out), 32'(exp_sum));
    chk("out_valid_done", 32'(out_valid), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("sum_valid_pulse", 32'(sum_valid), 32'd0);
    chk("sum_out_hold", 32'(sum_out), 32'(exp_sum));
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic set_v1();
    vin = '{8'sd16, 8'sd16, 8'sd16, 8'sd16, 8'sd16, 8'sd16, 8'sd16, 8'sd16};
`ifdef EXP_SEQ_MAX_SUB_EN
    exp_out = '{16, 16, 16, 16, 16, 16, 16, 16}; exp_sum = 128;
`else
    exp_out = '{46, 46, 46, 46, 46, 46, 46, 46}; exp_sum = 368;
`endif
  endtask

  task automatic set_v2();
    vin = '{8'sd127, -8'sd128, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
`ifdef EXP_SEQ_MAX_SUB_EN
    exp_out = '{16, 0, 0, 0, 0, 0, 0, 0}; exp_sum = 16;
`else
    exp_out = '{127, 0, 16, 16, 16, 16, 16, 16}; exp_sum = 223;
`endif
  endtask

  task automatic set_v3();
    vin = '{8'sd16, 8'sd0, -8'sd16, -8'sd32, 8'sd16, 8'sd0, -8'sd16, -8'sd32};
`ifdef EXP_SEQ_MAX_SUB_EN
    exp_out = '{16, 6, 2, 0, 16, 6, 2, 0}; exp_sum = 48;
`else
    exp_out = '{46, 16, 6, 2, 46, 16, 6, 2}; exp_sum = 140;
`endif
  endtask

  task automatic set_vn();
    vin = '{-8'sd8, -8'sd7, -8'sd6, -8'sd5, -8'sd4, -8'sd3, -8'sd2, -8'sd1};
`ifdef EXP_SEQ_MAX_SUB_EN
    exp_out = '{10, 11, 12, 13, 13, 14, 15, 16}; exp_sum = 104;
`else
    exp_out = '{10, 10, 11, 12, 13, 13, 14, 15}; exp_sum = 98;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_sum_out", 32'(sum_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // all-equal vector
    set_v1(); load_vec(); drain(-1);

    // clamp vector, then a second vector with in_valid held high through EXP/DONE
    set_v2(); load_vec();
    in_valid = 1'b1; in_data = -8'sd8;
    drain(-1);
    set_vn(); load_vec(); drain(-1);

    // backpressure on element 2
    set_v3(); load_vec(); drain(2);

    // reset after three outputs, then a fresh vector
    set_v1(); load_vec();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_out_data", 32'(out_data), 32'(exp_out[3]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sum_out", 32'(sum_out), 32'd0);
    chk("mid_rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    set_vn(); load_vec(); drain(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
